rgb_fader: RTL

Colour-fade sequencer that sits directly upstream of the LED-strip PWM stage. It accepts a target RGB colour through a valid/ready handshake. It then steps its three 8-bit duty outputs toward that target at a programmable rate, giving smooth transitions instead of abrupt colour jumps. The `RedPWM`/`GreenPWM`/`BluePWM` outputs connect one-to-one to the PWM stage's duty inputs.

---
 rtl/rgb_fader_pkg.sv | 12 +
 rtl/rgb_fade_channel.sv | 34 +++
 rtl/rgb_fader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rgb_fader_pkg.sv
// Shared types and constants for the RGB colour-fade sequencer.
package rgb_fader_pkg;

   localparam int DUTY_W           = 8;
   localparam int DEFAULT_STEP_DIV = 46875;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FADE = 1'b1
   } fade_state_e;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: moves the current duty toward the target by at most
// one step per strobe, clamping so it never overshoots or wraps.
module rgb_fade_channel
   import rgb_fader_pkg::*;
(
   input  logic [DUTY_W-1:0] cur_i,
   input  logic [DUTY_W-1:0] tgt_i,
   input  logic [DUTY_W-1:0] step_i,
   input  logic              strobe_i,
   output logic [DUTY_W-1:0] nxt_o,
   output logic              at_tgt_o
);

   logic signed [DUTY_W:0] diff_s;
   logic        [DUTY_W:0] mag_s;

   // Signed distance to target, its magnitude and the clamped next value
   always_comb begin
      diff_s = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
      mag_s  = diff_s[DUTY_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
      if (!strobe_i || (diff_s == '0)) begin
         nxt_o = cur_i;
      end else if ({1'b0, step_i} >= mag_s) begin
         nxt_o = tgt_i;
      end else if (diff_s[DUTY_W]) begin
         nxt_o = cur_i - step_i;
      end else begin
         nxt_o = cur_i + step_i;
      end
   end

   assign at_tgt_o = (nxt_o == tgt_i);

endmodule

// File: rtl/rgb_fader.sv
// Colour-fade sequencer: accepts a target RGB colour via valid/ready and
// steps the three registered PWM duties toward it every STEP_DIV cycles.
module rgb_fader
   import rgb_fader_pkg::*;
#(
   parameter int STEP_DIV = DEFAULT_STEP_DIV
) (
   input  logic              clk12MHz,
   input  logic              reset,
   input  logic              target_valid,
   output logic              target_ready,
   input  logic [DUTY_W-1:0] target_red,
   input  logic [DUTY_W-1:0] target_green,
   input  logic [DUTY_W-1:0] target_blue,
   input  logic [DUTY_W-1:0] step_size,
   output logic [DUTY_W-1:0] RedPWM,
   output logic [DUTY_W-1:0] GreenPWM,
   output logic [DUTY_W-1:0] BluePWM,
   output logic              busy,
   output logic              done
);

   localparam int                CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(STEP_DIV - 1);

   fade_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DUTY_W-1:0] tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
   logic [DUTY_W-1:0] step_q, step_d;
   logic [DUTY_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
   logic              done_q, done_d;

   logic              step_fire_s;
   logic [DUTY_W-1:0] red_nxt_s, grn_nxt_s, blu_nxt_s;
   logic              red_at_s, grn_at_s, blu_at_s;

   assign step_fire_s = (state_q == ST_FADE) && (cnt_q == TICK_LAST);

   rgb_fade_channel u_red (
      .cur_i(red_q), .tgt_i(tgt_r_q), .step_i(step_q), .strobe_i(step_fire_s),
      .nxt_o(red_nxt_s), .at_tgt_o(red_at_s)
   );
   rgb_fade_channel u_green (
      .cur_i(grn_q), .tgt_i(tgt_g_q), .step_i(step_q), .strobe_i(step_fire_s),
      .nxt_o(grn_nxt_s), .at_tgt_o(grn_at_s)
   );
   rgb_fade_channel u_blue (
      .cur_i(blu_q), .tgt_i(tgt_b_q), .step_i(step_q), .strobe_i(step_fire_s),
      .nxt_o(blu_nxt_s), .at_tgt_o(blu_at_s)
   );

   // Handshake, tick counter and fade sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_r_d = tgt_r_q;
      tgt_g_d = tgt_g_q;
      tgt_b_d = tgt_b_q;
      step_d  = step_q;
      red_d   = red_q;
      grn_d   = grn_q;
      blu_d   = blu_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (target_valid) begin
               tgt_r_d = target_red;
               tgt_g_d = target_green;
               tgt_b_d = target_blue;
               step_d  = (step_size == '0) ? DUTY_W'(1) : step_size;
               cnt_d   = '0;
               if ((target_red == red_q) && (target_green == grn_q) && (target_blue == blu_q)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FADE;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_FADE: begin
            if (step_fire_s) begin
               cnt_d = '0;
               red_d = red_nxt_s;
               grn_d = grn_nxt_s;
               blu_d = blu_nxt_s;
               if (red_at_s && grn_at_s && blu_at_s) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FADE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk12MHz) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tgt_r_q <= '0;
         tgt_g_q <= '0;
         tgt_b_q <= '0;
         step_q  <= DUTY_W'(1);
         red_q   <= '0;
         grn_q   <= '0;
         blu_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_r_q <= tgt_r_d;
         tgt_g_q <= tgt_g_d;
         tgt_b_q <= tgt_b_d;
         step_q  <= step_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         blu_q   <= blu_d;
         done_q  <= done_d;
      end
   end

   assign target_ready = (state_q == ST_IDLE) && !reset;
   assign busy         = (state_q == ST_FADE);
   assign done         = done_q;
   assign RedPWM       = red_q;
   assign GreenPWM     = grn_q;
   assign BluePWM      = blu_q;

endmodule
